// File: rtl/gost89_pkg.sv
// Shared types and helpers for the GOST 28147-89 ECB controller: FSM states,
// round counts and the round-number to key-word mapping.
package gost89_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int GOST_ROUNDS         = 32;
  localparam int GOST_MAC_ROUNDS_DEF = 16;

  // Encrypt: K0..K7 three times, then K7..K0. Decrypt: K0..K7, then K7..K0
  // three times. MAC: K0..K7 repeated. For 3 bits, 7-x == ~x.
  function automatic logic [2:0] key_idx(input logic [4:0] rnd,
                                         input logic       decrypt,
                                         input logic       mac);
    logic [2:0] idx;
    if (mac)
      idx = rnd[2:0];
    else if (decrypt)
      idx = (rnd < 5'd8) ? rnd[2:0] : ~rnd[2:0];
    else
      idx = (rnd < 5'd24) ? rnd[2:0] : ~rnd[2:0];
    return idx;
  endfunction

endpackage

// File: rtl/gost89_round.sv
// One GOST 28147-89 round: out1 = rotl11(S(n1 + k)) ^ n2, out2 = n1.
// S-box i (nibble i of the sum) entry j lives at sbox[64*i + 4*j +: 4].
module gost89_round (
  input  logic [511:0] sbox,
  input  logic [31:0]  n1,
  input  logic [31:0]  n2,
  input  logic [31:0]  k,
  output logic [31:0]  out1,
  output logic [31:0]  out2
);

  logic [31:0] sum;
  logic [31:0] sub;
  logic [8:0]  idx;

  always_comb begin
    sum = n1 + k;
    sub = '0;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      idx = {i[2:0], sum[4*i +: 4], 2'b00};
      sub[4*i +: 4] = sbox[idx +: 4];
    end
    out1 = {sub[20:0], sub[31:21]} ^ n2;
    out2 = n1;
  end

endmodule

// File: rtl/gost89_ecb_ctrl.sv
// Iterative GOST 28147-89 ECB engine: one round per clock through a single
// round datapath. Define GOST89_MAC_EN to enable the short MAC-mode blocks.
module gost89_ecb_ctrl
  import gost89_pkg::*;
#(
  parameter int GOST_MAC_ROUNDS = GOST_MAC_ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] sbox,
  input  logic         key_wr,
  input  logic [255:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         decrypt,
  input  logic         mac,
  input  logic [63:0]  din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  dout,
  output logic         busy
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  localparam logic [4:0] CIPHER_LAST = 5'(GOST_ROUNDS - 1);
  localparam logic [4:0] MAC_LAST    = 5'(GOST_MAC_ROUNDS - 1);

  logic [1:0]        state;
  logic [4:0]        rnd;
  logic [31:0]       n1, n2;
  logic [7:0][31:0]  kreg;
  logic              dec_q, mac_q;
  logic              mac_in;
  logic [31:0]       rkey, r_out1, r_out2;
  logic              last;

`ifdef GOST89_MAC_EN
  assign mac_in = mac;
`else
  // Port kept for interface compatibility; every block runs as a cipher block.
  assign mac_in = mac & 1'b0;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign rkey     = kreg[key_idx(rnd, dec_q, mac_q)];
  assign last     = (rnd == (mac_q ? MAC_LAST : CIPHER_LAST));

  gost89_round u_round (
    .sbox (sbox),
    .n1   (n1),
    .n2   (n2),
    .k    (rkey),
    .out1 (r_out1),
    .out2 (r_out2)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; the key words are reset too because a block
  // started right after reset without key_wr must see an all-zero key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rnd       <= '0;
      n1        <= '0;
      n2        <= '0;
      kreg      <= '0;
      dec_q     <= 1'b0;
      mac_q     <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_wr)
            kreg <= key;
          if (in_valid) begin
            n1    <= din[31:0];
            n2    <= din[63:32];
            dec_q <= decrypt;
            mac_q <= mac_in;
            rnd   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          n1  <= r_out1;
          n2  <= r_out2;
          rnd <= rnd + 5'd1;
          if (last) begin
            // Cipher output undoes the swap of the last round; MAC keeps it.
            dout      <= mac_q ? {r_out2, r_out1} : {r_out1, r_out2};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gost89_ecb_ctrl.md
GOST89_ECB_CTRL -- requirements
Module: gost89_ecb_ctrl

Interface
REQ-001 The block SHALL have parameter GOST_MAC_ROUNDS, default 16: round count used for MAC-mode blocks.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 sbox  in  512  S-box table; passed unchanged to the round datapath; held stable by the user while busy.
REQ-005 key_wr  in  1  key load strobe; honoured only in IDLE.
REQ-006 key  in  256  K0..K7; K0 = key[31:0], K7 = key[255:224].
REQ-007 in_valid / in_ready  in / out  1 / 1  input block handshake; transfer occurs when both are 1 on a rising edge.
REQ-008 decrypt  in  1  sampled with the block: 1 selects the decrypt key order.
REQ-009 mac  in  1  sampled with the block: 1 selects MAC mode (see Configuration).
REQ-010 din  in  64  block; N1 = din[31:0], N2 = din[63:32].
REQ-011 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-012 dout  out  64  result block.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, with in_ready = (state == IDLE) as a combinational output.
REQ-015 In IDLE, key_wr=1 SHALL register key on that edge; key_wr in RUN or DONE SHALL be ignored.
REQ-016 If key_wr and an accepted block occur on the same edge, the new key SHALL be loaded first and used for that block.
REQ-017 On accept, the block SHALL load n1/n2 from din, latch decrypt and mac, clear the round counter rnd (5 bits), and enter RUN.
REQ-018 Each RUN cycle SHALL apply one round (n1 <= round out1, n2 <= round out2) and then increment rnd.
REQ-019 Encrypt key index SHALL be rnd[2:0] for rnd 0..23 and 7-rnd[2:0] for rnd 24..31.
REQ-020 Decrypt key index SHALL be rnd[2:0] for rnd 0..7 and 7-rnd[2:0] for rnd 8..31.
REQ-021 MAC mode key index SHALL be rnd[2:0] for all rounds.
REQ-022 After the final round (rnd 31, or GOST_MAC_ROUNDS-1 in MAC mode), the FSM SHALL go to DONE and set out_valid.
REQ-023 Timing: with accept at edge T, out_valid SHALL be high from edge T+32 (T+GOST_MAC_ROUNDS in MAC mode).
REQ-024 In cipher mode, dout SHALL be {n1,n2}, i.e. dout[31:0]=n2 and dout[63:32]=n1, which undoes the last-round swap.
REQ-025 In MAC mode, dout SHALL be {n2,n1}, i.e. no final swap.
REQ-026 In DONE, dout and out_valid SHALL be held until out_ready=1; on that edge out_valid SHALL clear and the FSM return to IDLE.
REQ-027 A new block SHALL NOT be accepted in the same cycle as the output handoff, so minimum spacing is 34 cycles per block.
REQ-028 in_valid SHALL be ignored outside IDLE, and din, decrypt and mac changes during RUN SHALL have no effect.

Reset
REQ-029 On rst_n=0 the block SHALL immediately force: state IDLE, out_valid 0, dout 0, n1/n2 0, rnd 0, key registers 0, and latched decrypt/mac 0.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the block with no output produced; in_ready SHALL be 1 on the first edge after rst_n rises.

Configuration
REQ-031 With GOST89_MAC_EN defined, the mac input SHALL behave as in REQ-009, REQ-021, REQ-022, REQ-023 and REQ-025.
REQ-032 With GOST89_MAC_EN undefined, the mac port SHALL remain present but be ignored (treated as 0), and all blocks SHALL run 32 cipher rounds.

Structure
REQ-033 Package gost89_pkg SHALL hold: the state enum, constant GOST_ROUNDS=32, the default MAC round count, and a function mapping (rnd, decrypt, mac) to key index.
REQ-034 The block SHALL instantiate exactly one gost89_round as the sole round datapath and reuse it iteratively; the block SHALL NOT unroll rounds.

Verification
REQ-035 S-box outputs all zero, key 0, din=64'h0123456789ABCDEF, encrypt -> dout=64'h89ABCDEF01234567 exactly 32 cycles after accept.
REQ-036 Random key/sbox/din, encrypt, then decrypt the result with the same key -> dout equals the original din; repeat for 1000 blocks.
REQ-037 out_ready held 0 for 10 cycles after out_valid -> dout stable, in_ready 0, and in_valid pulses are ignored throughout.
REQ-038 key_wr pulsed at rnd=10 -> result matches the old key; the next block uses the old key unless key_wr is reissued in IDLE.
REQ-039 rst_n pulsed low at rnd=20 -> out_valid never rises for that block; the next block gives the correct result.
REQ-040 GOST89_MAC_EN defined, mac=1 -> out_valid at T+16 with dout matching the reference model; undefined, mac=1 -> output identical to a mac=0 encrypt.
